// File: rtl/interfaces_def_pkg.sv
// Types shared by the vector load/store unit: FSM states, RAM request record, word width.
package interfaces_def_pkg;

   localparam int DMU_WORD_W = 32;
   localparam int DMU_ADDR_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_DRAIN,
      ST_DONE
   } dmu_vec_state_t;

   typedef struct packed {
      logic [DMU_ADDR_W-1:0] addr;
      logic [DMU_WORD_W-1:0] wdata;
      logic                  wr_en;
   } dmu_ram_req_t;

endpackage

// File: rtl/data_mem_unit_vec_n_rd_lat_pipe.sv
// rd_lat_pipe: RD_LAT-deep shift register of {valid, lane index} tracking loads in flight.
module rd_lat_pipe #(
   parameter int RD_LAT = 2,
   parameter int LANE_W = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              push,
   input  logic [LANE_W-1:0] push_lane,
   output logic              capture,
   output logic [LANE_W-1:0] capture_lane,
   output logic              pending
);

   logic [RD_LAT-1:0] valid;
   logic [LANE_W-1:0] lane [RD_LAT];

   // NOTE: the lane tags are a handful of flops, not a RAM, so resetting them is cheap and keeps the pipe deterministic.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid <= '0;
         for (int j = 0; j < RD_LAT; j++) lane[j] <= '0;
      end else begin
         valid[0] <= push;
         lane[0]  <= push_lane;
         for (int j = 1; j < RD_LAT; j++) begin
            valid[j] <= valid[j-1];
            lane[j]  <= lane[j-1];
         end
      end
   end

   assign capture      = valid[RD_LAT-1];
   assign capture_lane = lane[RD_LAT-1];

   // Entries still in flight behind the one being captured this cycle.
   // NOTE: combinational logic uses blocking '=' with a default first, so no latch is inferred.
   always_comb begin
      pending = 1'b0;
      for (int j = 0; j < RD_LAT - 1; j++) pending = pending | valid[j];
   end

endmodule

// File: rtl/data_mem_unit_vec_n.sv
// Vector load/store unit: serialises LANES words onto a 32-bit RAM port and reassembles loads.
// Optional strided addressing is enabled by defining DMU_STRIDE_EN.
module data_mem_unit_vec_n
   import interfaces_def_pkg::*;
#(
   parameter int LANES  = 2,
   parameter int WORD_W = DMU_WORD_W,
   parameter int ADDR_W = 32,
   parameter int RD_LAT = 2
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    mem_start,
   input  logic                    wr_en,
   input  logic [ADDR_W-1:0]       cpu_addr,
`ifdef DMU_STRIDE_EN
   input  logic [7:0]              stride,
`endif
   input  logic [LANES*WORD_W-1:0] vec_data_in,
   input  logic [WORD_W-1:0]       mem_data_read,
   output logic [ADDR_W-1:0]       ram_addr,
   output logic [WORD_W-1:0]       ram_wdata,
   output logic                    ram_wr_en,
   output logic [LANES*WORD_W-1:0] vec_data_out,
   output logic                    mem_ready,
   output logic                    busy
);

   localparam int LANE_W = $clog2(LANES);
   localparam int VEC_W  = LANES * WORD_W;

   dmu_vec_state_t    state;
   logic              store_op;
   logic [LANE_W-1:0] lane_idx;
   logic [VEC_W-1:0]  data_q;
   logic [ADDR_W-1:0] addr_step;
   logic              cap;
   logic [LANE_W-1:0] cap_lane;
   logic              pending;

`ifdef DMU_STRIDE_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                          addr_step <= ADDR_W'(1);
      else if (state == ST_IDLE && mem_start) addr_step <= ADDR_W'(stride);
   end
`else
   assign addr_step = ADDR_W'(1);
`endif

   // The RAM port is registered: the access for lane i is loaded one edge ahead of the
   // cycle it is presented in, so lane 0 is set up on the start edge itself.
   // NOTE: sequential state uses non-blocking '<=' so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         store_op  <= 1'b0;
         lane_idx  <= '0;
         data_q    <= '0;
         ram_addr  <= '0;
         ram_wdata <= '0;
         ram_wr_en <= 1'b0;
         mem_ready <= 1'b0;
      end else begin
         mem_ready <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (mem_start) begin
                  state     <= ST_ISSUE;
                  store_op  <= wr_en;
                  lane_idx  <= '0;
                  ram_addr  <= cpu_addr;
                  ram_wr_en <= wr_en;
                  if (wr_en) ram_wdata <= vec_data_in[VEC_W-1 -: WORD_W];
                  data_q    <= vec_data_in << WORD_W;
               end
            end
            ST_ISSUE: begin
               if (lane_idx == LANE_W'(LANES - 1)) begin
                  ram_wr_en <= 1'b0;
                  state     <= store_op ? ST_DONE : ST_DRAIN;
                  mem_ready <= store_op;
               end else begin
                  lane_idx <= lane_idx + LANE_W'(1);
                  ram_addr <= ram_addr + addr_step;
                  if (store_op) ram_wdata <= data_q[VEC_W-1 -: WORD_W];
                  data_q   <= data_q << WORD_W;
               end
            end
            ST_DRAIN: begin
               if (!pending) begin
                  state     <= ST_DONE;
                  mem_ready <= 1'b1;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign busy = (state != ST_IDLE);

   rd_lat_pipe #(
      .RD_LAT (RD_LAT),
      .LANE_W (LANE_W)
   ) u_rd_lat_pipe (
      .clk          (clk),
      .reset_n      (reset_n),
      .push         ((state == ST_ISSUE) && !store_op),
      .push_lane    (lane_idx),
      .capture      (cap),
      .capture_lane (cap_lane),
      .pending      (pending)
   );

   // Lane 0 (base address) lands in the most-significant word of the result.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vec_data_out <= '0;
      end else if (cap) begin
         for (int l = 0; l < LANES; l++) begin
            if (cap_lane == LANE_W'(l)) vec_data_out[(LANES-1-l)*WORD_W +: WORD_W] <= mem_data_read;
         end
      end
   end

endmodule

// File: tb/tb_data_mem_unit_vec_n.sv
// Directed bench for data_mem_unit_vec_n (LANES=2, RD_LAT=2) with a latency-accurate RAM model.
module tb_data_mem_unit_vec_n;
   import interfaces_def_pkg::*;

   localparam int LANES  = 2;
   localparam int RD_LAT = 2;

   logic                 clk;
   logic                 reset_n;
   logic                 mem_start;
   logic                 wr_en;
   logic [31:0]          cpu_addr;
`ifdef DMU_STRIDE_EN
   logic [7:0]           stride;
`endif
   logic [LANES*32-1:0]  vec_data_in;
   logic [31:0]          mem_data_read;
   logic [31:0]          ram_addr;
   logic [31:0]          ram_wdata;
   logic                 ram_wr_en;
   logic [LANES*32-1:0]  vec_data_out;
   logic                 mem_ready;
   logic                 busy;

   int n_cmp = 0;
   int n_bad = 0;
   int n_rdy;

   dmu_ram_req_t req;
   assign req = '{addr: ram_addr, wdata: ram_wdata, wr_en: ram_wr_en};

   data_mem_unit_vec_n #(
      .LANES  (LANES),
      .RD_LAT (RD_LAT)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .mem_start     (mem_start),
      .wr_en         (wr_en),
      .cpu_addr      (cpu_addr),
`ifdef DMU_STRIDE_EN
      .stride        (stride),
`endif
      .vec_data_in   (vec_data_in),
      .mem_data_read (mem_data_read),
      .ram_addr      (ram_addr),
      .ram_wdata     (ram_wdata),
      .ram_wr_en     (ram_wr_en),
      .vec_data_out  (vec_data_out),
      .mem_ready     (mem_ready),
      .busy          (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM model: 256 words indexed by the low address byte, RD_LAT-cycle read pipe.
   logic [31:0] mem [256];
   logic [31:0] rd_pipe [RD_LAT];

   initial begin
      for (int a = 0; a < 256; a++) mem[a] = 32'hBAD0_0000 | 32'(a);
      mem[8'h20] = 32'h1111_1111;
      mem[8'h21] = 32'h2222_2222;
      for (int j = 0; j < RD_LAT; j++) rd_pipe[j] = '0;
   end

   always @(posedge clk) begin
      if (ram_wr_en) mem[ram_addr[7:0]] <= ram_wdata;
      rd_pipe[0] <= mem[ram_addr[7:0]];
      for (int j = 1; j < RD_LAT; j++) rd_pipe[j] <= rd_pipe[j-1];
   end
   assign mem_data_read = rd_pipe[RD_LAT-1];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Called at a negedge; the start is sampled on the following rising edge (edge 0).
   task automatic start_op(input logic wr, input logic [31:0] addr, input logic [63:0] data);
      mem_start   = 1'b1;
      wr_en       = wr;
      cpu_addr    = addr;
      vec_data_in = data;
      @(posedge clk);
      #1 mem_start = 1'b0;
   endtask

   // Runs a two-lane load from the current negedge; returns after cycle 6 (IDLE again).
   task automatic run_load(input string name, input logic [31:0] a0, input logic [31:0] a1,
                           input logic [63:0] exp_vec);
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         check($sformatf("%s_c%0d_ready", name, c), mem_ready, (c == 5) ? 1 : 0);
         if (c == 1) check($sformatf("%s_addr0", name), req.addr, a0);
         if (c == 2) check($sformatf("%s_addr1", name), req.addr, a1);
         if (c <= 2) check($sformatf("%s_c%0d_wr", name, c), req.wr_en, 0);
         if (c == 5) check($sformatf("%s_vec", name), vec_data_out, exp_vec);
      end
   endtask

   initial begin
      reset_n     = 1'b0;
      mem_start   = 1'b0;
      wr_en       = 1'b0;
      cpu_addr    = '0;
      vec_data_in = '0;
`ifdef DMU_STRIDE_EN
      stride      = 8'd1;
`endif
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check("rst_addr",  ram_addr, 0);
      check("rst_wdata", ram_wdata, 0);
      check("rst_wr",    ram_wr_en, 0);
      check("rst_vec",   vec_data_out, 0);
      check("rst_ready", mem_ready, 0);
      check("rst_busy",  busy, 0);

      // Store: MSW to the base address first.
      start_op(1'b1, 32'h10, 64'hAAAA_BBBB_CCCC_DDDD);
      @(negedge clk);
      check("st_c1_addr",  req.addr, 32'h10);
      check("st_c1_wdata", req.wdata, 32'hAAAA_BBBB);
      check("st_c1_wr",    req.wr_en, 1);
      check("st_c1_busy",  busy, 1);
      check("st_c1_ready", mem_ready, 0);
      @(negedge clk);
      check("st_c2_addr",  req.addr, 32'h11);
      check("st_c2_wdata", req.wdata, 32'hCCCC_DDDD);
      check("st_c2_wr",    req.wr_en, 1);
      check("st_c2_ready", mem_ready, 0);
      @(negedge clk);
      check("st_c3_ready", mem_ready, 1);
      check("st_c3_wr",    req.wr_en, 0);
      check("st_c3_addr_hold", req.addr, 32'h11);
      check("st_c3_busy",  busy, 1);
      @(negedge clk);
      check("st_c4_ready", mem_ready, 0);
      check("st_c4_busy",  busy, 0);
      check("st_ram_lo",   mem[8'h10], 32'hAAAA_BBBB);
      check("st_ram_hi",   mem[8'h11], 32'hCCCC_DDDD);
      check("st_vec_kept", vec_data_out, 0);

      // Load with RD_LAT=2: ready in cycle LANES+RD_LAT+1 = 5.
      start_op(1'b0, 32'h20, 64'h0);
      run_load("ld", 32'h20, 32'h21, 64'h1111_1111_2222_2222);

      // Start pulse during cycle 2 of a store must be dropped.
      start_op(1'b1, 32'h30, 64'h3333_3333_4444_4444);
      @(negedge clk);
      @(negedge clk);
      check("ign_c2_ready", mem_ready, 0);
      mem_start = 1'b1;
      wr_en     = 1'b0;
      cpu_addr  = 32'h90;
      @(posedge clk);
      #1 mem_start = 1'b0;
      n_rdy = 0;
      for (int c = 3; c <= 8; c++) begin
         @(negedge clk);
         if (mem_ready) n_rdy++;
         if (c == 4) check("ign_c4_busy", busy, 0);
      end
      check("ign_ready_count", n_rdy, 1);
      check("ign_addr_hold", req.addr, 32'h31);
      check("ign_ram_hi", mem[8'h31], 32'h4444_4444);

      // Back-to-back store then load, mem_start held high throughout.
      mem_start   = 1'b1;
      wr_en       = 1'b1;
      cpu_addr    = 32'h40;
      vec_data_in = 64'h0123_4567_89AB_CDEF;
      @(posedge clk);
      #1;
      wr_en       = 1'b0;
      vec_data_in = '0;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         check($sformatf("b2b_c%0d_ready", c), mem_ready, (c == 3 || c == 9) ? 1 : 0);
         if (c == 3) check("b2b_vec_kept", vec_data_out, 64'h1111_1111_2222_2222);
         if (c == 4) check("b2b_c4_busy", busy, 0);
         if (c == 5) begin
            check("b2b_ld_addr0", req.addr, 32'h40);
            check("b2b_ld_wr",    req.wr_en, 0);
            check("b2b_ld_busy",  busy, 1);
         end
         if (c == 9) check("b2b_vec", vec_data_out, 64'h0123_4567_89AB_CDEF);
         if (c == 4) begin
            @(posedge clk);
            #1 mem_start = 1'b0;
         end
      end

      // Reset in cycle 2 of a store aborts immediately.
      start_op(1'b1, 32'h50, 64'h5555_5555_6666_6666);
      @(negedge clk);
      check("ab_c1_wr", req.wr_en, 1);
      @(negedge clk);
      check("ab_c2_addr", req.addr, 32'h51);
      #2 reset_n = 1'b0;
      #1;
      check("ab_wr",    ram_wr_en, 0);
      check("ab_addr",  ram_addr, 0);
      check("ab_wdata", ram_wdata, 0);
      check("ab_busy",  busy, 0);
      check("ab_ready", mem_ready, 0);
      check("ab_vec",   vec_data_out, 0);
      @(negedge clk);
      reset_n = 1'b1;
      n_rdy = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (mem_ready) n_rdy++;
      end
      check("ab_ready_count", n_rdy, 0);
      check("ab_ram_written", mem[8'h50], 32'h5555_5555);
      check("ab_ram_untouched", mem[8'h51], 32'hBAD0_0051);

`ifdef DMU_STRIDE_EN
      stride = 8'd3;
      start_op(1'b0, 32'hFFFF_FFFE, 64'h0);
      run_load("sd3", 32'hFFFF_FFFE, 32'h0000_0001, 64'hBAD0_00FE_BAD0_0001);
      stride = 8'd0;
      start_op(1'b0, 32'h20, 64'h0);
      run_load("sd0_ld", 32'h20, 32'h20, 64'h1111_1111_1111_1111);
      start_op(1'b1, 32'h60, 64'h7777_7777_8888_8888);
      repeat (4) @(negedge clk);
      check("sd0_st_last_wins", mem[8'h60], 32'h8888_8888);
      check("sd0_st_next_untouched", mem[8'h61], 32'hBAD0_0061);
`else
      start_op(1'b0, 32'hFFFF_FFFF, 64'h0);
      run_load("wrap", 32'hFFFF_FFFF, 32'h0000_0000, 64'hBAD0_00FF_BAD0_0000);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
